// File: rtl/mux_scan_sel.sv
// Registered N-channel mux with an auto-scan sequencer.
// Manual mode follows sel; scan mode sweeps channels with a fixed dwell.
module mux_scan_sel #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  din,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic            y_valid,
    output logic [SELW-1:0] ch,
    output logic            wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW:0]   NCH   = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);
    localparam logic [DW-1:0]   DLAST = DW'(DWELL - 1);

    logic [SELW-1:0] ptr, ptr_n, ch_n, idx;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [W-1:0]    y_n, pick;
    logic            valid_n, wrap_n;
    logic            hold, man, scan, in_range;

    assign hold     = !en;
    assign man      = en && !mode;
    assign scan     = en && mode;
    assign in_range = {1'b0, sel} < NCH;
    assign idx      = mode ? ptr : sel;

    // Explicit compare chain keeps out-of-range selects from reading past din.
    always_comb begin
        pick = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) pick = din[k*W +: W];
        end
    end

    always_comb begin
        y_n     = y;
        ch_n    = ch;
        ptr_n   = ptr;
        dcnt_n  = dcnt;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        unique case (1'b1)
            hold: ;
            man: begin
                if (in_range) begin
                    y_n     = pick;
                    ch_n    = sel;
                    ptr_n   = sel;
                    dcnt_n  = '0;
                    valid_n = 1'b1;
                end else begin
                    y_n = '0;
                end
            end
            scan: begin
                y_n     = pick;
                ch_n    = ptr;
                valid_n = 1'b1;
                if (dcnt == DLAST) begin
                    dcnt_n = '0;
                    ptr_n  = (ptr == LAST) ? '0 : ptr + SELW'(1);
                    wrap_n = (ptr == LAST);
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            ch      <= '0;
            wrap    <= 1'b0;
            ptr     <= '0;
            dcnt    <= '0;
        end else begin
            y       <= y_n;
            y_valid <= valid_n;
            ch      <= ch_n;
            wrap    <= wrap_n;
            ptr     <= ptr_n;
            dcnt    <= dcnt_n;
        end
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised N-channel, W-bit registered multiplexer with a built-in auto-scan sequencer. It is the clocked successor to the team's 8x1 single-bit mux.
- Manual mode: it selects the channel given by an external select.
- Scan mode: it steps through every channel itself, holding each for DWELL cycles, and pulses a wrap flag at the end of each sweep.
- It sits between multi-channel sample sources and a single downstream consumer, for example a display or serial logger.

Parameters:
N, 8, number of input channels (N >= 2; need not be a power of 2)
W, 8, bits per channel
SELW, 3, select/pointer width; must satisfy 2**SELW >= N
DWELL, 4, enabled cycles spent on each channel in scan mode (DWELL >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  N*W  packed channels; channel k occupies din[k*W +: W]
sel  input  SELW  manual channel select
mode  input  1  0 = manual, 1 = scan
en  input  1  advance/sample enable
y  output  W  registered selected data
y_valid  output  1  y holds valid data from channel ch
ch  output  SELW  index of the channel y was taken from
wrap  output  1  one-cycle pulse: last dwell cycle of channel N-1 in scan mode

Behaviour:
- Single clock. Reset is asynchronous, active-low. All state registers update on the rising edge of clk.
- Reset values: y=0, y_valid=0, ch=0, wrap=0, internal scan pointer ptr=0, dwell counter dcnt=0. Reset asserted mid-scan aborts the scan immediately; after release, scanning restarts at channel 0 with a fresh dwell.
- Latency: one cycle. Inputs sampled at edge t appear on y/ch/y_valid after edge t.
- Operating states, decoded each cycle from en and mode:
  - HOLD (en=0)
  - MANUAL (en=1, mode=0)
  - SCAN (en=1, mode=1)
  - There is no stored FSM state besides ptr and dcnt. The transition rules below are the state behaviour.
- HOLD:
  - y, ch, ptr and dcnt hold their values.
  - y_valid <= 0 and wrap <= 0.
- MANUAL with sel < N:
  - y <= channel sel; ch <= sel; y_valid <= 1.
  - ptr <= sel; dcnt <= 0; wrap <= 0.
- MANUAL with sel >= N (out of range):
  - y <= 0; y_valid <= 0; ch, ptr and dcnt hold; wrap <= 0.
  - No X propagation.
- SCAN:
  - y <= channel ptr; ch <= ptr; y_valid <= 1.
  - If dcnt == DWELL-1:
    - dcnt <= 0.
    - ptr <= (ptr == N-1) ? 0 : ptr+1.
    - wrap <= (ptr == N-1).
  - Otherwise: dcnt <= dcnt+1; wrap <= 0.
- Data is tracking, not latched once per dwell: every SCAN cycle re-samples din[ptr].
- Mode switches:
  - MANUAL->SCAN: scanning resumes from the last valid manual channel (ptr) with a full DWELL.
  - SCAN->MANUAL: takes effect at the next edge. The partial dwell is discarded because dcnt is cleared.
- HOLD inside SCAN: dwell and pointer freeze, so the dwell count is measured in enabled cycles only. On resume, the remaining dwell completes.
- DWELL=1: ptr advances every enabled SCAN cycle.
- Non-power-of-2 N: ptr never exceeds N-1; the wrap back to 0 happens at N-1.
- dcnt width is clog2(DWELL), minimum 1 bit. No arithmetic overflow is possible.

Test Plan:
- Reset/manual: N=8, W=8, DWELL=4, din channel k = 8'h10+k, rst_n low then high, en=1, mode=0, sel=5 -> after reset y=0, y_valid=0, ch=0; one edge later y=8'h15, ch=5, y_valid=1.
- Out-of-range select: N=6, sel=7 in MANUAL -> y=0, y_valid=0, ch keeps previous value; then sel=2 -> y=8'h12, y_valid=1 next cycle.
- Full scan sweep: mode=1, en=1 from reset, 32 cycles -> y holds 8'h10 for 4 cycles, then 8'h11 for 4, ... through 8'h17. wrap=1 exactly on the cycle of the 4th 8'h17 sample and in no other cycle. The sweep then restarts at 8'h10.
- Enable gating mid-dwell: during SCAN on ch=3 after 2 samples, drop en for 5 cycles, then restore -> y_valid=0 and y frozen at 8'h13 while en=0; on resume, ch=3 for 2 more cycles, then ch=4.
- Mode switch and live data: MANUAL sel=6, then mode=1 -> scan starts at ch=6 for 4 cycles, then 7 with wrap, then 0. Changing din channel 6 to 8'hAA mid-dwell -> y=8'hAA on the next edge.
- Async reset mid-scan: assert rst_n between clock edges while on ch=5 -> y, ch, y_valid and wrap go to 0 immediately, without waiting for a clock edge. After release, the scan restarts at ch=0 with a full dwell.
